// File: rtl/mcdf_formatter_if.sv
// mcdf_formatter_if: formatter output bus, request/grant handshake plus packet beat signals.
interface mcdf_formatter_if #(parameter int CMD_WIDE = 32);
  logic fmt_req, fmt_grant, fmt_valid, fmt_start, fmt_end;
  logic [1:0] fmt_chid;
  logic [3:0] fmt_length;
  logic [CMD_WIDE-1:0] fmt_data;
  modport master(output fmt_req, fmt_chid, fmt_length, fmt_valid, fmt_start, fmt_end, fmt_data, input fmt_grant);
  modport slave(input fmt_req, fmt_chid, fmt_length, fmt_valid, fmt_start, fmt_end, fmt_data, output fmt_grant);
endinterface

// File: rtl/mcdf_formatter.sv
// mcdf_formatter: arbitrates three channel FIFOs by priority and drains the winner as a fixed-length packet.
// Define FMT_RR_EN to break equal-priority ties round-robin instead of by lowest channel index.
module mcdf_formatter #(
  parameter int CMD_WIDE      = 32,
  parameter int FIFO_PTR_WIDE = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_slave0_en,
  input  logic                   cmd_slave1_en,
  input  logic                   cmd_slave2_en,
  input  logic [1:0]             cmd_fifo0_priority,
  input  logic [1:0]             cmd_fifo1_priority,
  input  logic [1:0]             cmd_fifo2_priority,
  input  logic [2:0]             cmd_fifo0_length,
  input  logic [2:0]             cmd_fifo1_length,
  input  logic [2:0]             cmd_fifo2_length,
  input  logic [CMD_WIDE-1:0]    ch0_data,
  input  logic [CMD_WIDE-1:0]    ch1_data,
  input  logic [CMD_WIDE-1:0]    ch2_data,
  input  logic [FIFO_PTR_WIDE:0] ch0_level,
  input  logic [FIFO_PTR_WIDE:0] ch1_level,
  input  logic [FIFO_PTR_WIDE:0] ch2_level,
  output logic                   ch0_pop,
  output logic                   ch1_pop,
  output logic                   ch2_pop,
  mcdf_formatter_if.master       fmt
);
  typedef enum logic [2:0] {IDLE = 3'b001, REQ = 3'b010, SEND = 3'b100} state_t;
  state_t r_state;
  logic [1:0] r_chid;
  logic [3:0] r_len;
  logic [2:0] r_cnt, r_pop;
  logic r_req, r_valid, r_start, r_end;
  logic [1:0] w_pri [3];
  logic [2:0] w_code [3];
  logic [3:0] w_len [3];
  logic [FIFO_PTR_WIDE:0] w_lvl [3];
  logic [CMD_WIDE-1:0] w_data [3];
  logic [2:0] w_en, w_elig;
  logic w_found, w_last;
  logic [1:0] w_win, w_best, w_idx;
`ifdef FMT_RR_EN
  logic [1:0] r_ptr;
  logic [2:0] w_sum;
`endif
  function automatic logic [3:0] decode(input logic [2:0] c);
    return c == 3'd0 ? 4'd1 : c == 3'd1 ? 4'd2 : c == 3'd2 ? 4'd4 : 4'd8;
  endfunction
  assign w_en   = {cmd_slave2_en, cmd_slave1_en, cmd_slave0_en};
  assign w_pri  = '{cmd_fifo0_priority, cmd_fifo1_priority, cmd_fifo2_priority};
  assign w_code = '{cmd_fifo0_length, cmd_fifo1_length, cmd_fifo2_length};
  assign w_lvl  = '{ch0_level, ch1_level, ch2_level};
  assign w_data = '{ch0_data, ch1_data, ch2_data};
  for (genvar g = 0; g < 3; g++) begin : g_elig
    assign w_len[g]  = decode(w_code[g]);
    assign w_elig[g] = w_en[g] && (32'(w_lvl[g]) >= 32'(w_len[g]));
  end
  // Strict '<' keeps the first candidate in search order on a priority tie.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_best  = 2'd3;
    w_idx   = 2'd0;
`ifdef FMT_RR_EN
    w_sum   = 3'd0;
`endif
    for (int k = 0; k < 3; k++) begin
`ifdef FMT_RR_EN
      w_sum = {1'b0, r_ptr} + 3'(k);
      w_idx = w_sum > 3'd2 ? 2'(w_sum - 3'd3) : w_sum[1:0];
`else
      w_idx = 2'(k);
`endif
      if (w_elig[w_idx] && (!w_found || w_pri[w_idx] < w_best)) begin
        w_found = 1'b1;
        w_win   = w_idx;
        w_best  = w_pri[w_idx];
      end
    end
  end
  assign w_last = {1'b0, r_cnt} == r_len - 4'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_chid  <= 2'd0;
      r_len   <= 4'd0;
      r_cnt   <= 3'd0;
      r_pop   <= 3'd0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
`ifdef FMT_RR_EN
      r_ptr   <= 2'd0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_state <= REQ;
          r_chid  <= w_win;
          r_len   <= w_len[w_win];
          r_req   <= 1'b1;
        end
        REQ: if (fmt.fmt_grant) begin
          r_state <= SEND;
          r_req   <= 1'b0;
          r_valid <= 1'b1;
          r_start <= 1'b1;
          r_end   <= r_len == 4'd1;
          r_cnt   <= 3'd0;
          r_pop   <= 3'b001 << r_chid;
`ifdef FMT_RR_EN
          r_ptr   <= r_chid == 2'd2 ? 2'd0 : r_chid + 2'd1;
`endif
        end
        SEND: if (w_last) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_start <= 1'b0;
          r_end   <= 1'b0;
          r_pop   <= 3'd0;
          r_cnt   <= 3'd0;
        end else begin
          r_cnt   <= r_cnt + 3'd1;
          r_start <= 1'b0;
          r_end   <= ({1'b0, r_cnt} + 4'd2) == r_len;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign fmt.fmt_req    = r_req;
  assign fmt.fmt_chid   = r_chid;
  assign fmt.fmt_length = r_len;
  assign fmt.fmt_valid  = r_valid;
  assign fmt.fmt_start  = r_start;
  assign fmt.fmt_end    = r_end;
  assign fmt.fmt_data   = r_valid ? w_data[r_chid] : '0;
  assign {ch2_pop, ch1_pop, ch0_pop} = r_pop;
endmodule

// File: tb/tb_mcdf_formatter.sv
// tb_mcdf_formatter: directed and random packets checked against a FIFO/arbitration reference model.
module tb_mcdf_formatter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en [3];
  logic [1:0] pri [3];
  logic [2:0] code [3];
  logic [31:0] dat [3];
  logic [3:0] lvl [3];
  logic p0, p1, p2;
  logic [31:0] q [3][$];
  int n_chk = 0, n_fail = 0, ptr = 0;
  bit in_gap = 0;
  mcdf_formatter_if #(.CMD_WIDE(32)) fif ();
  mcdf_formatter #(.CMD_WIDE(32), .FIFO_PTR_WIDE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_slave0_en(en[0]), .cmd_slave1_en(en[1]), .cmd_slave2_en(en[2]),
    .cmd_fifo0_priority(pri[0]), .cmd_fifo1_priority(pri[1]), .cmd_fifo2_priority(pri[2]),
    .cmd_fifo0_length(code[0]), .cmd_fifo1_length(code[1]), .cmd_fifo2_length(code[2]),
    .ch0_data(dat[0]), .ch1_data(dat[1]), .ch2_data(dat[2]),
    .ch0_level(lvl[0]), .ch1_level(lvl[1]), .ch2_level(lvl[2]),
    .ch0_pop(p0), .ch1_pop(p1), .ch2_pop(p2),
    .fmt(fif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int blen(input logic [2:0] c);
    return 1 << (c > 3'd3 ? 3 : int'(c));
  endfunction
  function automatic bit elig(input int c);
    return en[c] === 1'b1 && q[c].size() >= blen(code[c]);
  endfunction
  // Reference arbitration: lowest priority value, then search order from the round-robin start.
  function automatic int pick();
    int best, ch, c;
    best = 4;
    ch = -1;
    for (int i = 0; i < 3; i++) if (elig(i) && int'(pri[i]) < best) best = int'(pri[i]);
    for (int k = 0; k < 3; k++) begin
`ifdef FMT_RR_EN
      c = (ptr + k) % 3;
`else
      c = k;
`endif
      if (ch < 0 && elig(c) && int'(pri[c]) == best) ch = c;
    end
    return ch;
  endfunction
  task automatic refresh();
    for (int i = 0; i < 3; i++) begin
      lvl[i] = 4'(q[i].size());
      dat[i] = q[i].size() > 0 ? q[i][0] : 32'h0;
    end
  endtask
  task automatic fill(input int c, input int n);
    repeat (n) if (q[c].size() < 8) q[c].push_back($urandom);
    refresh();
  endtask
  task automatic drain();
    for (int i = 0; i < 3; i++) q[i].delete();
    refresh();
  endtask
  task automatic tick();
    logic [2:0] w;
    logic [31:0] e;
    @(posedge clk);
    #1;
    w = {p2, p1, p0};
    if (fif.fmt_valid === 1'b1 && fif.fmt_chid < 2'd3) begin
      e = q[fif.fmt_chid].size() > 0 ? q[fif.fmt_chid][0] : 'x;
      chk("beat_pop", 64'(w), 64'(3'b001 << fif.fmt_chid));
      chk("beat_data", 64'(fif.fmt_data), 64'(e));
      if (q[fif.fmt_chid].size() > 0) void'(q[fif.fmt_chid].pop_front());
    end else begin
      chk("idle_pop", 64'(w), 64'(0));
      chk("idle_data", 64'(fif.fmt_data), 64'(0));
    end
    refresh();
  endtask
  task automatic idle_check(input int n);
    repeat (n) begin
      tick();
      chk("no_req", 64'({fif.fmt_req, fif.fmt_valid}), 64'(0));
    end
    in_gap = 0;
  endtask
  task automatic run_packet(input int gd, input bit mut, input int abort);
    int ch, len;
    ch = pick();
    if (ch < 0) begin
      idle_check(2);
      return;
    end
    len = blen(code[ch]);
    fif.fmt_grant = gd == 0;
    if (in_gap) begin
      tick();
      chk("gap_req", 64'(fif.fmt_req), 64'(0));
    end
    tick();
    chk("req_rise", 64'(fif.fmt_req), 64'(1));
    chk("req_chid", 64'(fif.fmt_chid), 64'(ch));
    chk("req_len", 64'(fif.fmt_length), 64'(len));
    for (int s = 0; s < gd; s++) begin
      if (mut) begin
        code[ch] = 3'($urandom_range(0, 7));
        en[ch] = 1'b0;
      end
      tick();
      chk("stall", 64'({fif.fmt_req, fif.fmt_valid, fif.fmt_chid, fif.fmt_length}), 64'({1'b1, 1'b0, 2'(ch), 4'(len)}));
    end
    fif.fmt_grant = 1'b1;
    for (int b = 0; b < len; b++) begin
      tick();
      if (b == 0) begin
        ptr = (ch + 1) % 3;
        chk("beat0_req", 64'(fif.fmt_req), 64'(0));
      end
      chk("beat_flags", 64'({fif.fmt_valid, fif.fmt_start, fif.fmt_end, fif.fmt_chid, fif.fmt_length}),
          64'({1'b1, b == 0, b == len - 1, 2'(ch), 4'(len)}));
      if (b == abort) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({fif.fmt_req, fif.fmt_valid, fif.fmt_start, fif.fmt_end, fif.fmt_chid, fif.fmt_length, p2, p1, p0}), 64'(0));
        chk("async_rst_data", 64'(fif.fmt_data), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        ptr = 0;
        in_gap = 0;
        fif.fmt_grant = 1'b0;
        return;
      end
    end
    fif.fmt_grant = 1'b0;
    in_gap = 1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      pri[i] = 2'd0;
      code[i] = 3'd0;
    end
    refresh();
    fif.fmt_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 64'({fif.fmt_req, fif.fmt_valid, fif.fmt_start, fif.fmt_end, fif.fmt_chid, fif.fmt_length, p2, p1, p0}), 64'(0));
    chk("rst_data", 64'(fif.fmt_data), 64'(0));
    rst_n = 1'b1;
    en[0] = 1'b1;
    code[0] = 3'd2;
    fill(0, 4);
    run_packet(0, 0, -1);
    drain();
    en = '{1'b1, 1'b1, 1'b1};
    pri = '{2'd2, 2'd1, 2'd3};
    code = '{3'd1, 3'd1, 3'd1};
    for (int i = 0; i < 3; i++) fill(i, 2);
    repeat (3) run_packet(0, 0, -1);
    drain();
    pri = '{2'd0, 2'd0, 2'd0};
    code = '{3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 3; i++) fill(i, 8);
    repeat (6) run_packet(0, 0, -1);
    drain();
    en = '{1'b1, 1'b0, 1'b0};
    code[0] = 3'd3;
    fill(0, 7);
    idle_check(4);
    fill(0, 1);
    run_packet(0, 0, -1);
    code[0] = 3'd6;
    fill(0, 8);
    run_packet(0, 0, -1);
    drain();
    code[0] = 3'd2;
    fill(0, 4);
    run_packet(5, 1, -1);
    drain();
    en[0] = 1'b1;
    code[0] = 3'd3;
    fill(0, 8);
    run_packet(0, 0, 2);
    code[0] = 3'd2;
    run_packet(0, 0, -1);
    repeat (25) begin
      for (int i = 0; i < 3; i++) begin
        en[i] = $urandom_range(0, 3) != 0;
        pri[i] = 2'($urandom_range(0, 3));
        code[i] = 3'($urandom_range(0, 7));
        fill(i, $urandom_range(0, 8));
      end
      if (pick() < 0) idle_check(2);
      else run_packet($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
